pwm_mc_core: RTL
================

Name: pwm_mc_core

Overview:
- Parametrised multi-channel PWM timer core; next generation of the APB4 PWM peripheral's counter/compare datapath.
- Adds over the current block:
  - configurable channel count and counter width;
  - edge-aligned and center-aligned modes;
  - per-channel output polarity;
  - double-buffered (shadow) configuration, applied only at period boundaries;
  - a valid/ready configuration handshake.
- Sits between an APB4 register front-end (not part of this block) and the pads, in the same clock domain as the bus.

Parameters:
CH_NUM, 4, number of PWM channels (1..16)
CNT_W, 16, counter/compare width in bits (2..32)
PSCR_W, 16, prescaler width in bits

Ports:
clk_i  in  1  core clock
rst_i  in  1  asynchronous, active-high reset
en_i  in  1  counter enable (level)
cfg_valid_i  in  1  new configuration offered
cfg_ready_o  out  1  configuration can be accepted
cfg_mode_i  in  1  0 = edge-aligned, 1 = center-aligned
cfg_pscr_i  in  PSCR_W  prescaler; tick period = pscr+1 clocks
cfg_cmp_i  in  CNT_W  period top value
cfg_crr_i  in  CH_NUM*CNT_W  per-channel duty thresholds, channel i at [i*CNT_W +: CNT_W]
cfg_pol_i  in  CH_NUM  per-channel polarity, 1 = inverted
pwm_o  out  CH_NUM  PWM outputs, registered
cnt_o  out  CNT_W  current counter value
dir_o  out  1  0 = counting up, 1 = counting down
upd_o  out  1  one-cycle pulse when the shadow set is applied
ovf_o  out  1  one-cycle pulse at each period boundary

Behaviour:
- Reset (asynchronous, active-high):
  - active and pending sets (mode, pscr, cmp, crr, pol) = 0; pending flag = 0;
  - prescaler count = 0; cnt = 0; dir = 0;
  - pwm_o = 0; upd_o = ovf_o = 0; cfg_ready_o = 1 on the first edge after release.
- Handshake:
  - cfg_ready_o = ~pending.
  - Transfer occurs on valid & ready: all cfg_* inputs are captured into the pending set and pending is set.
  - cfg_valid_i while not ready is ignored; the master holds it.
- Apply (active <= pending, pending cleared, upd_o pulses):
  - if en_i = 0: one cycle after capture;
  - if en_i = 1: on the boundary tick (defined below).
  - cfg_ready_o goes high the cycle after apply, so capture and apply never coincide.
- Prescaler:
  - tick when prescaler count == active pscr, then the count returns to 0; otherwise it increments.
  - pscr = 0 gives a tick every clock.
  - A pscr change takes effect from the apply; the prescaler count is cleared at apply.
- Edge mode:
  - on a tick, cnt increments; when cnt == cmp it wraps to 0;
  - boundary tick = tick with cnt == cmp;
  - dir_o = 0.
- Center mode:
  - dir 0: increment; at cnt == cmp, set dir = 1 and cnt = cmp-1.
  - dir 1: decrement; at cnt == 0, set dir = 0 and cnt = 1.
  - boundary tick = tick with cnt == 0 and dir = 1.
  - Period = 2*cmp ticks.
- cmp = 0 (both modes): cnt holds 0, dir = 0, and every tick is a boundary.
- ovf_o: pulses in the clock cycle of each boundary tick. upd_o coincides with it when pending is set.
- Mode change: only at apply. cnt, dir and prescaler count are reset to 0 at every apply while enabled.
  - Resolution of the apply/counter race: when the apply resets cnt to 0, this overrides the wrap value.
- Output:
  - pwm_o[i] <= en_i ? ((cnt < crr[i]) ^ pol[i]) : pol[i], registered.
  - pwm_o therefore lags cnt_o by 1 clock.
  - crr = 0 gives 0% duty.
  - crr > cmp gives 100% duty in both modes.
  - Edge-mode duty = crr/(cmp+1).
- Disable (en_i = 0):
  - next clock: cnt = 0, dir = 0, prescaler count = 0, no ticks, no ovf_o;
  - outputs go to the idle level pol.
- Enable (en_i 0->1): counting starts from 0; the first tick is pscr+1 clocks after the rising edge.
- Widths:
  - comparisons are unsigned CNT_W;
  - the counter never exceeds cmp, so it cannot overflow;
  - the prescaler count is PSCR_W bits.
- Reset mid-period: all state clears immediately and any pending configuration is discarded.

Test Plan:
- Reset, then en=0; configure edge mode, pscr=0, cmp=9, crr0=3, pol=0; then en=1 -> cnt_o cycles 0..9; pwm_o[0] is high 3 of every 10 clocks; ovf_o pulses every 10 clocks at cnt=9.
- Center mode, pscr=1, cmp=4, crr0=2 -> ticks every 2 clocks; cnt sequence 0,1,2,3,4,3,2,1,0,1...; period 16 clocks; ovf_o at cnt=0 with dir=1; pwm_o[0] high while cnt<2.
- While running with cmp=9, offer cmp=4 mid-period -> cfg_ready_o drops; the old period completes; upd_o and ovf_o pulse together; the next period has length 5; cfg_ready_o returns high 1 clock after upd_o.
- Boundaries: crr=0 -> pwm_o constantly 0; crr=cmp+1 -> constantly 1; pol=1 inverts both; cmp=0 -> ovf_o pulses on every tick.
- Deassert en_i mid-count -> cnt_o=0 and pwm_o=pol the next clock. Reassert -> the first increment comes pscr+1 clocks later.
- Assert rst_i mid-period with a configuration pending -> all outputs 0 asynchronously; the pending set is discarded; cfg_ready_o=1 after release.

Source files
------------

// File: rtl/pwm_mc_core.sv
// rtl/pwm_mc_core.sv - multi-channel PWM timer core with shadowed configuration
// Edge/center-aligned counter, per-channel compare and polarity, valid/ready config capture.
module pwm_mc_core #(
  parameter int CH_NUM = 4,
  parameter int CNT_W  = 16,
  parameter int PSCR_W = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    cfg_valid_i,
  output logic                    cfg_ready_o,
  input  logic                    cfg_mode_i,
  input  logic [PSCR_W-1:0]       cfg_pscr_i,
  input  logic [CNT_W-1:0]        cfg_cmp_i,
  input  logic [CH_NUM*CNT_W-1:0] cfg_crr_i,
  input  logic [CH_NUM-1:0]       cfg_pol_i,
  output logic [CH_NUM-1:0]       pwm_o,
  output logic [CNT_W-1:0]        cnt_o,
  output logic                    dir_o,
  output logic                    upd_o,
  output logic                    ovf_o
);

  logic                    act_mode, pend_mode;
  logic [PSCR_W-1:0]       act_pscr, pend_pscr;
  logic [CNT_W-1:0]        act_cmp, pend_cmp;
  logic [CH_NUM*CNT_W-1:0] act_crr, pend_crr;
  logic [CH_NUM-1:0]       act_pol, pend_pol;
  logic                    pending;

  logic [PSCR_W-1:0]       pcnt;
  logic [CNT_W-1:0]        cnt_q, cnt_nx;
  logic                    dir_q, dir_nx;
  logic                    tick, bnd, apply, capture, pending_nx;

  assign cnt_o   = cnt_q;
  assign dir_o   = dir_q;
  assign capture = cfg_valid_i & cfg_ready_o;
  assign tick    = en_i & (pcnt == act_pscr);

  // Next counter value and boundary detection for the current tick.
  always_comb begin
    cnt_nx = cnt_q;
    dir_nx = dir_q;
    bnd    = 1'b0;
    if (tick) begin
      if (act_cmp == '0) begin
        cnt_nx = '0;
        dir_nx = 1'b0;
        bnd    = 1'b1;
      end else if (!act_mode) begin
        bnd    = (cnt_q == act_cmp);
        cnt_nx = bnd ? '0 : cnt_q + CNT_W'(1);
        dir_nx = 1'b0;
      end else if (!dir_q) begin
        if (cnt_q == act_cmp) begin
          dir_nx = 1'b1;
          cnt_nx = act_cmp - CNT_W'(1);
        end else begin
          cnt_nx = cnt_q + CNT_W'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          bnd    = 1'b1;
          dir_nx = 1'b0;
          cnt_nx = CNT_W'(1);
        end else begin
          cnt_nx = cnt_q - CNT_W'(1);
        end
      end
    end
  end

  assign apply      = pending & (~en_i | bnd);
  assign pending_nx = capture | (pending & ~apply);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      act_mode    <= 1'b0;
      act_pscr    <= '0;
      act_cmp     <= '0;
      act_crr     <= '0;
      act_pol     <= '0;
      pend_mode   <= 1'b0;
      pend_pscr   <= '0;
      pend_cmp    <= '0;
      pend_crr    <= '0;
      pend_pol    <= '0;
      pending     <= 1'b0;
      pcnt        <= '0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      pwm_o       <= '0;
      upd_o       <= 1'b0;
      ovf_o       <= 1'b0;
      cfg_ready_o <= 1'b0;
    end else begin
      upd_o       <= apply;
      ovf_o       <= bnd;
      pending     <= pending_nx;
      // Ready stays low through the apply cycle so capture never meets apply.
      cfg_ready_o <= ~pending_nx & ~apply;

      if (!en_i || apply) begin
        cnt_q <= '0;
        dir_q <= 1'b0;
        pcnt  <= '0;
      end else if (tick) begin
        cnt_q <= cnt_nx;
        dir_q <= dir_nx;
        pcnt  <= '0;
      end else begin
        pcnt  <= pcnt + PSCR_W'(1);
      end

      if (capture) begin
        pend_mode <= cfg_mode_i;
        pend_pscr <= cfg_pscr_i;
        pend_cmp  <= cfg_cmp_i;
        pend_crr  <= cfg_crr_i;
        pend_pol  <= cfg_pol_i;
      end

      if (apply) begin
        act_mode <= pend_mode;
        act_pscr <= pend_pscr;
        act_cmp  <= pend_cmp;
        act_crr  <= pend_crr;
        act_pol  <= pend_pol;
      end

      for (int i = 0; i < CH_NUM; i++) begin
        pwm_o[i] <= en_i ? ((cnt_q < act_crr[i*CNT_W +: CNT_W]) ^ act_pol[i]) : act_pol[i];
      end
    end
  end

endmodule
